// File: rtl/top_core.sv
// top_core: registered multi-function datapath.
// One flat operand/control bus in, one flat registered result bus out.
// Each cycle: 32x32 multiply, 16-op ALU, accumulator, CRC-16/CCITT byte
// update, free-running cycle counter and a flag vector.
// Optional build macro TOP_CORE_ACC_SAT_EN: when defined, accumulate mode
// saturates at 32'hFFFFFFFF instead of wrapping.
module top_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [137:0] in_flat,
    output logic [158:0] out_flat
);

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [3:0]  op;
    logic [1:0]  mode;
    logic [4:0]  sh;

    assign a    = in_flat[31:0];
    assign b    = in_flat[63:32];
    assign c    = in_flat[95:64];
    assign d    = in_flat[127:96];
    assign op   = in_flat[131:128];
    assign mode = in_flat[137:136];
    assign sh   = c[4:0];

    // Reserved control bits carry no meaning; fold them so they are visibly consumed.
    logic unused_reserved;
    assign unused_reserved = ^in_flat[135:132];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [63:0] mul_reg,   mul_next;
    logic [31:0] alu_reg,   alu_next;
    logic [31:0] acc_reg,   acc_next;
    logic [15:0] crc_reg,   crc_next;
    logic [7:0]  cnt_reg,   cnt_next;
    logic [6:0]  flags_reg, flags_next;

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    assign mul_next = {32'b0, a} * {32'b0, b};

    // ------------------------------------------------------------------
    // ALU helper terms
    // ------------------------------------------------------------------
    logic [32:0] add_wide;
    logic [32:0] sub_wide;
    logic [63:0] rot_wide;
    logic [31:0] sra_val;
    logic [31:0] c_byterev;
    logic [5:0]  pop_count;
    logic [5:0]  lead_zeros;

    assign add_wide = {1'b0, c} + {1'b0, d};
    // Bit 32 of the 33-bit difference is the unsigned borrow (C < D).
    assign sub_wide = {1'b0, c} - {1'b0, d};
    // Rotating by shifting a doubled copy keeps sh=0 free of a 32-bit shift.
    assign rot_wide = {d, d} << sh;
    assign sra_val  = $signed(d) >>> sh;

    // Byte reversal wired as four independent byte lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byterev
            assign c_byterev[gi*8 +: 8] = c[(3-gi)*8 +: 8];
        end
    endgenerate

    // Population count of C.
    always_comb begin
        pop_count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            pop_count = pop_count + {5'b0, c[i]};
        end
    end

    // Leading-zero count of C; the highest set bit wins, 32 when C is zero.
    always_comb begin
        lead_zeros = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (c[i]) begin
                lead_zeros = 6'(31 - i);
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU result, carry and overflow
    // ------------------------------------------------------------------
    logic carry_next;
    logic ovf_next;

    // Operation select plus the arithmetic status bits for add/sub.
    always_comb begin
        alu_next   = d;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        case (op)
            4'd0: begin
                alu_next   = add_wide[31:0];
                carry_next = add_wide[32];
                ovf_next   = (c[31] == d[31]) && (add_wide[31] != c[31]);
            end
            4'd1: begin
                alu_next   = sub_wide[31:0];
                carry_next = sub_wide[32];
                ovf_next   = (c[31] != d[31]) && (sub_wide[31] != c[31]);
            end
            4'd2:    alu_next = c & d;
            4'd3:    alu_next = c | d;
            4'd4:    alu_next = c ^ d;
            4'd5:    alu_next = d << sh;
            4'd6:    alu_next = d >> sh;
            4'd7:    alu_next = sra_val;
            4'd8:    alu_next = rot_wide[63:32];
            4'd9:    alu_next = (c < d) ? c : d;
            4'd10:   alu_next = (c < d) ? d : c;
            4'd11:   alu_next = {31'b0, ($signed(c) < $signed(d))};
            4'd12:   alu_next = {26'b0, pop_count};
            4'd13:   alu_next = {26'b0, lead_zeros};
            4'd14:   alu_next = c_byterev;
            default: alu_next = d;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator and sticky wrap/saturate flag
    // ------------------------------------------------------------------
    logic [32:0] acc_sum;
    logic        sticky_next;

    assign acc_sum = {1'b0, acc_reg} + {1'b0, alu_next};

    // Mode-driven accumulator update; the sticky bit only ever sets here.
    always_comb begin
        acc_next    = acc_reg;
        sticky_next = flags_reg[3];
        case (mode)
            2'd1: begin
                if (acc_sum[32]) begin
                    sticky_next = 1'b1;
                end
`ifdef TOP_CORE_ACC_SAT_EN
                acc_next = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
`else
                acc_next = acc_sum[31:0];
`endif
            end
            2'd2:    acc_next = acc_reg ^ a;
            2'd3:    acc_next = 32'd0;
            default: acc_next = acc_reg;
        endcase
    end

    // ------------------------------------------------------------------
    // CRC-16/CCITT over C[7:0], MSB first, one bit per chain stage
    // ------------------------------------------------------------------
    logic [15:0] crc_chain [0:8];

    assign crc_chain[0] = crc_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_crc
            assign crc_chain[gi+1] = {crc_chain[gi][14:0], 1'b0}
                                   ^ ((crc_chain[gi][15] ^ c[7-gi]) ? CRC_POLY : 16'h0000);
        end
    endgenerate

    assign crc_next = crc_chain[8];

    // ------------------------------------------------------------------
    // Counter and flags
    // ------------------------------------------------------------------
    assign cnt_next = cnt_reg + 8'd1;

    assign flags_next = {1'b1,
                         ^alu_next,
                         |mul_next[63:32],
                         sticky_next,
                         ovf_next,
                         carry_next,
                         (alu_next == 32'd0)};

    // All result fields register together; reset overrides every input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_reg   <= 64'd0;
            alu_reg   <= 32'd0;
            acc_reg   <= 32'd0;
            crc_reg   <= CRC_INIT;
            cnt_reg   <= 8'd0;
            flags_reg <= 7'd0;
        end else begin
            mul_reg   <= mul_next;
            alu_reg   <= alu_next;
            acc_reg   <= acc_next;
            crc_reg   <= crc_next;
            cnt_reg   <= cnt_next;
            flags_reg <= flags_next;
        end
    end

    assign out_flat = {flags_reg, cnt_reg, crc_reg, acc_reg, alu_reg, mul_reg};

endmodule

// File: tb/tb_top_core.sv
// tb_top_core: self-checking bench for top_core with a behavioural model.
// Honours TOP_CORE_ACC_SAT_EN so the model matches the built variant.
module tb_top_core;

`ifdef TOP_CORE_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [158:0] RESET_VAL = {7'd0, 8'd0, 16'hFFFF, 32'd0, 32'd0, 64'd0};

    logic         clk;
    logic         rst_n;
    logic [137:0] in_flat;
    logic [158:0] out_flat;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Model state
    logic [63:0] m_mul;
    logic [31:0] m_alu;
    logic [31:0] m_acc;
    logic [15:0] m_crc;
    logic [7:0]  m_cnt;
    logic        m_sticky;
    logic [6:0]  m_flags;

    top_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_flat  (in_flat),
        .out_flat (out_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ALU behaviour written straight from the operation table.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] c,
                                            input logic [31:0] d);
        int          sh;
        int          n;
        logic [31:0] r;
        sh = int'(c[4:0]);
        r  = 32'd0;
        case (op)
            4'd0:  r = c + d;
            4'd1:  r = c - d;
            4'd2:  r = c & d;
            4'd3:  r = c | d;
            4'd4:  r = c ^ d;
            4'd5:  r = d << sh;
            4'd6:  r = d >> sh;
            4'd7:  r = d[31] ? ~((~d) >> sh) : (d >> sh);
            4'd8:  r = (sh == 0) ? d : ((d << sh) | (d >> (32 - sh)));
            4'd9:  r = (c < d) ? c : d;
            4'd10: r = (c > d) ? c : d;
            4'd11: r = ($signed(c) < $signed(d)) ? 32'd1 : 32'd0;
            4'd12: r = 32'($countones(c));
            4'd13: begin
                n = 0;
                while (n < 32 && c[31-n] == 1'b0) n++;
                r = 32'(n);
            end
            4'd14: r = {c[7:0], c[15:8], c[23:16], c[31:24]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [158:0] exp_out();
        return {m_flags, m_cnt, m_crc, m_acc, m_alu, m_mul};
    endfunction

    // Advance the model by one rising edge.
    task automatic model_tick(input logic rst, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d,
                              input logic [3:0] op, input logic [1:0] mode);
        logic [31:0] r;
        longint      sc, sd, s, sum;
        logic        carry, ovf, fb;
        if (!rst) begin
            m_mul = 64'd0; m_alu = 32'd0; m_acc = 32'd0; m_crc = 16'hFFFF;
            m_cnt = 8'd0; m_sticky = 1'b0; m_flags = 7'd0;
        end else begin
            r     = ref_alu(op, c, d);
            m_mul = 64'(a) * 64'(b);
            carry = 1'b0;
            ovf   = 1'b0;
            sc    = longint'($signed(c));
            sd    = longint'($signed(d));
            if (op == 4'd0) begin
                carry = (longint'(c) + longint'(d)) > longint'(32'hFFFF_FFFF);
                s     = sc + sd;
                ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end else if (op == 4'd1) begin
                carry = c < d;
                s     = sc - sd;
                ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            case (mode)
                2'd1: begin
                    sum = longint'(m_acc) + longint'(r);
                    if (sum > longint'(32'hFFFF_FFFF)) begin
                        m_sticky = 1'b1;
                        m_acc    = SAT ? 32'hFFFF_FFFF : 32'(sum);
                    end else begin
                        m_acc = 32'(sum);
                    end
                end
                2'd2: m_acc = m_acc ^ a;
                2'd3: m_acc = 32'd0;
                default: ;
            endcase
            for (int i = 7; i >= 0; i--) begin
                fb    = m_crc[15] ^ c[i];
                m_crc = {m_crc[14:0], 1'b0};
                if (fb) m_crc = m_crc ^ 16'h1021;
            end
            m_cnt   = m_cnt + 8'd1;
            m_alu   = r;
            m_flags = {1'b1, ^r, (m_mul[63:32] != 32'd0), m_sticky, ovf, carry, (r == 32'd0)};
        end
    endtask

    // Drive one transaction, clock it, update the model, sample after the edge.
    task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input logic [3:0] op, input logic [1:0] mode);
        rst_n   = rst;
        in_flat = {mode, 4'($urandom), op, d, c, b, a};
        @(posedge clk);
        model_tick(rst, a, b, c, d, op, mode);
        #1;
        cyc++;
        $display("[TB] cyc=%0d rst_n=%0b op=%0d mode=%0d out=%h", cyc, rst, op, mode, out_flat);
    endtask

    task automatic step_rand(input logic rst);
        step(rst, $urandom, $urandom, $urandom, $urandom, 4'($urandom), 2'($urandom));
    endtask

    task automatic test_reset();
        step_rand(1'b0);
        step_rand(1'b0);
        tests_run++;
        if (out_flat !== RESET_VAL) begin
            tests_failed++;
            $display("[TB] FAIL reset_value: got %h want %h", out_flat, RESET_VAL);
        end
        step(1'b1, $urandom, $urandom, $urandom, $urandom, 4'($urandom), 2'd0);
        tests_run++;
        if (out_flat[151:144] !== 8'd1 || out_flat[158] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL first_edge: cnt=%h valid=%b want cnt=01 valid=1",
                     out_flat[151:144], out_flat[158]);
        end
        tests_run++;
        if (out_flat !== exp_out()) begin
            tests_failed++;
            $display("[TB] FAIL first_edge_model: got %h want %h", out_flat, exp_out());
        end
    endtask

    task automatic test_mul_add();
        step(1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd1, 4'd0, 2'd0);
        tests_run++;
        if (out_flat[63:0] !== 64'h1_FFFF_FFFE) begin
            tests_failed++;
            $display("[TB] FAIL mul: got %h want 00000001fffffffe", out_flat[63:0]);
        end
        tests_run++;
        if (out_flat[95:64] !== 32'd0 || out_flat[152] !== 1'b1 || out_flat[153] !== 1'b1 ||
            out_flat[156] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL add_flags: alu=%h flags=%b want alu=0 zero,carry,mulhi=1",
                     out_flat[95:64], out_flat[158:152]);
        end
        tests_run++;
        if (out_flat !== exp_out()) begin
            tests_failed++;
            $display("[TB] FAIL mul_add_model: got %h want %h", out_flat, exp_out());
        end
    endtask

    task automatic test_overflow_sticky();
        logic [31:0] acc_want;
        acc_want = SAT ? 32'hFFFF_FFFF : 32'd0;
        step(1'b1, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'd1, 4'd0, 2'd0);
        tests_run++;
        if (out_flat[95:64] !== 32'h8000_0000 || out_flat[154] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overflow: alu=%h ovf=%b want 80000000 ovf=1",
                     out_flat[95:64], out_flat[154]);
        end
        step(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 2'd3);
        step(1'b1, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 4'd0, 2'd2);
        tests_run++;
        if (out_flat[127:96] !== 32'hFFFF_FFF0) begin
            tests_failed++;
            $display("[TB] FAIL acc_xor: got %h want fffffff0", out_flat[127:96]);
        end
        step(1'b1, 32'd0, 32'd0, 32'h10, 32'd0, 4'd0, 2'd1);
        tests_run++;
        if (out_flat[127:96] !== acc_want || out_flat[155] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL acc_wrap: acc=%h sticky=%b want %h sticky=1",
                     out_flat[127:96], out_flat[155], acc_want);
        end
        step(1'b1, 32'd0, 32'd0, 32'd5, 32'd3, 4'd2, 2'd3);
        tests_run++;
        if (out_flat[127:96] !== 32'd0 || out_flat[155] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL acc_clear_sticky: acc=%h sticky=%b want 0 sticky=1",
                     out_flat[127:96], out_flat[155]);
        end
        tests_run++;
        if (out_flat !== exp_out()) begin
            tests_failed++;
            $display("[TB] FAIL sticky_model: got %h want %h", out_flat, exp_out());
        end
    endtask

    task automatic test_alu_sweep();
        logic [3:0]  ops  [0:9] = '{4'd5, 4'd7, 4'd8, 4'd13, 4'd14, 4'd12,
                                    4'd5, 4'd6, 4'd8, 4'd7};
        logic [31:0] cs   [0:9] = '{32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4,
                                    32'h20, 32'h20, 32'h20, 32'h1F};
        logic [31:0] wants[0:9] = '{32'h0000_0010, 32'hF800_0000, 32'h0000_0018,
                                    32'h0000_001D, 32'h0400_0000, 32'h0000_0001,
                                    32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
                                    32'hFFFF_FFFF};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, $urandom, cs[i], 32'h8000_0001, ops[i], 2'd0);
            tests_run++;
            if (out_flat[95:64] !== wants[i]) begin
                tests_failed++;
                $display("[TB] FAIL alu_op%0d: got %h want %h", ops[i], out_flat[95:64], wants[i]);
            end
        end
        step(1'b1, $urandom, $urandom, 32'h0, 32'h0, 4'd13, 2'd0);
        tests_run++;
        if (out_flat[95:64] !== 32'd32) begin
            tests_failed++;
            $display("[TB] FAIL clz_zero: got %h want 00000020", out_flat[95:64]);
        end
    endtask

    task automatic test_crc();
        step_rand(1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, $urandom, $urandom, {$urandom_range(0, 16'hFFFF), 8'h0, 8'(8'h31 + i)} , $urandom,
                 4'($urandom), 2'($urandom));
        end
        tests_run++;
        if (out_flat[143:128] !== 16'h29B1) begin
            tests_failed++;
            $display("[TB] FAIL crc_check: got %h want 29b1", out_flat[143:128]);
        end
    endtask

    task automatic test_counter_wrap();
        step_rand(1'b0);
        for (int i = 0; i < 256; i++) step_rand(1'b1);
        tests_run++;
        if (out_flat[151:144] !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL cnt_wrap: got %h want 00", out_flat[151:144]);
        end
        tests_run++;
        if (out_flat !== exp_out()) begin
            tests_failed++;
            $display("[TB] FAIL cnt_wrap_model: got %h want %h", out_flat, exp_out());
        end
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, $urandom, $urandom, 4'd0, 2'd1);
        step(1'b0, $urandom, $urandom, $urandom, $urandom, 4'($urandom), 2'd1);
        tests_run++;
        if (out_flat !== RESET_VAL) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got %h want %h", out_flat, RESET_VAL);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step_rand(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);
            tests_run++;
            if (out_flat !== exp_out()) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d: got %h want %h", i, out_flat, exp_out());
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        in_flat = '0;
        m_mul = 64'd0; m_alu = 32'd0; m_acc = 32'd0; m_crc = 16'hFFFF;
        m_cnt = 8'd0; m_sticky = 1'b0; m_flags = 7'd0;
        @(negedge clk);
        test_reset();
        test_mul_add();
        test_overflow_sticky();
        test_alu_sweep();
        test_crc();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
